// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART's 8-bit AXI-stream transmit port among
// NUM_REQ requesters. The grant is held for a whole packet, which ends on tlast
// or after MAX_BEATS payload beats. An optional channel header byte is sent
// ahead of each packet so the far end can demultiplex the stream.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned HEADER_EN = 1,
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ*8-1:0] s_axis_tdata_i,
  input  logic [NUM_REQ-1:0]   s_axis_tvalid_i,
  input  logic [NUM_REQ-1:0]   s_axis_tlast_i,
  output logic [NUM_REQ-1:0]   s_axis_tready_o,
  output logic [7:0]           m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST   = CNT_W'(MAX_BEATS - 1);
  localparam logic [7:0]       HDR_BASE    = 8'hA0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_PASS   = 2'd2
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    id;
  logic [ID_W-1:0]    last_id;
  logic [CNT_W-1:0]   beat_cnt;

  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               handshake;
  logic               pkt_end;

  // Round-robin pick: first requester above last_id, else the lowest one (wrap)
  always_comb begin
    pick_vld    = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && s_axis_tvalid_i[k] && (ID_W'(k) > last_id)) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && s_axis_tvalid_i[k]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pick_onehot[k] = (pick_id == ID_W'(k));
    end
  end

  // Select the granted requester's stream
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (id == ID_W'(k)) begin
        sel_valid = s_axis_tvalid_i[k];
        sel_last  = s_axis_tlast_i[k];
        sel_data  = s_axis_tdata_i[8*k +: 8];
      end
    end
  end

  assign handshake = (state == S_PASS) && sel_valid && m_axis_tready_i;
  assign pkt_end   = handshake && (sel_last || (beat_cnt == BEAT_LAST));

  // Master side and per-requester ready: combinational, no data-path registers
  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    s_axis_tready_o = '0;
    case (state)
      S_HEADER: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = HDR_BASE | 8'(id);
      end
      S_PASS: begin
        m_axis_tvalid_o = sel_valid;
        m_axis_tdata_o  = sel_data;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          s_axis_tready_o[k] = (id == ID_W'(k)) && m_axis_tready_i;
        end
      end
      default: ;
    endcase
  end

  // Grant FSM with registered grant/busy and beat counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      id       <= '0;
      last_id  <= LAST_ID_RST;
      beat_cnt <= '0;
      grant_o  <= '0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            id       <= pick_id;
            grant_o  <= pick_onehot;
            busy_o   <= 1'b1;
            beat_cnt <= '0;
            state    <= (HEADER_EN != 0) ? S_HEADER : S_PASS;
          end
        end
        S_HEADER: begin
          if (m_axis_tready_i) begin
            state <= S_PASS;
          end
        end
        S_PASS: begin
          if (handshake) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (pkt_end) begin
            state   <= S_IDLE;
            last_id <= id;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
